// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - write-back stage select encodings and FSM state type
package wb_pkg;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_LHB = 2'b10;
    localparam logic [1:0] WB_LLB = 2'b11;

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } wb_state_t;

endpackage

// File: rtl/wb_data_sel.sv
// rtl/wb_data_sel.sv - write-back data select with LHB byte merge and LLB sign extension
module wb_data_sel
    import wb_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 8
) (
    input  logic [1:0]        wb_sel,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [IMM_W-1:0]  imm,
    input  logic [DATA_W-1:0] old_dst,
    output logic [DATA_W-1:0] wdata
);

    localparam int LOW_W = DATA_W - IMM_W;

    // LHB only keeps the low part of the old destination value
    logic unused_old_hi;
    assign unused_old_hi = ^old_dst[DATA_W-1:LOW_W];

    always_comb begin
        wdata = alu_res;
        case (wb_sel)
            WB_ALU:  wdata = alu_res;
            WB_MEM:  wdata = mem_data;
            WB_LHB:  wdata = {imm, old_dst[LOW_W-1:0]};
            WB_LLB:  wdata = {{LOW_W{imm[IMM_W-1]}}, imm};
            default: wdata = alu_res;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB pipeline register, register-file write port, forwarding bus, halt FSM
// Optional retire counter output enabled by defining WB_RETIRE_CNT_EN.
module wb_stage
    import wb_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int IMM_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [1:0]        in_wb_sel,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [DATA_W-1:0] in_old_dst,
    input  logic [ADDR_W-1:0] in_dst,
    input  logic              in_we,
    input  logic              in_hlt,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_dst,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_dst,
    output logic [DATA_W-1:0] fwd_data,
`ifdef WB_RETIRE_CNT_EN
    output logic [15:0]       retire_cnt,
`endif
    output logic              halted
);

    wb_state_t         state_q, state_d;
    logic              valid_q, we_q, hlt_q;
    logic [ADDR_W-1:0] dst_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] sel_data;

    wb_data_sel #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_data_sel (
        .wb_sel   (in_wb_sel),
        .alu_res  (in_alu_res),
        .mem_data (in_mem_data),
        .imm      (in_imm),
        .old_dst  (in_old_dst),
        .wdata    (sel_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            hlt_q   <= 1'b0;
            dst_q   <= '0;
            wdata_q <= '0;
        end else if (state_q == ST_HALTED) begin
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (!stall) begin
            valid_q <= in_valid;
            // HLT never writes a register, whatever in_we says
            we_q    <= in_we & ~in_hlt;
            hlt_q   <= in_hlt;
            dst_q   <= in_dst;
            wdata_q <= sel_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (valid_q && hlt_q) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    assign rf_we     = valid_q & we_q & (dst_q != '0) & (state_q == ST_RUN);
    assign rf_dst    = dst_q;
    assign rf_wdata  = wdata_q;
    assign fwd_valid = rf_we;
    assign fwd_dst   = dst_q;
    assign fwd_data  = wdata_q;
    assign halted    = (state_q == ST_HALTED);

`ifdef WB_RETIRE_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (valid_q && !stall && state_q == ST_RUN) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign retire_cnt = cnt_q;
`endif

endmodule
